// File: rtl/lap_store.sv
// Lap-time capture and recall buffer: keeps the last DEPTH {m,s,ms} captures
// in a circular buffer and presents one of them, registered, on request.
module lap_store #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = 2
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic [W-1:0]  ms,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  m,
  input  logic          lap,
  input  logic          recall,
  input  logic          clear,
  output logic [W-1:0]  lap_ms,
  output logic [W-1:0]  lap_s,
  output logic [W-1:0]  lap_m,
  output logic [AW-1:0] lap_age,
  output logic [AW:0]   lap_cnt,
  output logic          view,
  output logic          full
);

  localparam int unsigned EW = 3 * W;

  typedef enum logic {IDLE = 1'b0, VIEW = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   age_q, age_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            view_q, view_d;
  logic [EW-1:0]   disp_q, disp_d;
  logic            wr_en;
  logic [AW-1:0]   rd_idx;
  logic [EW-1:0]   live;

  assign live = {m, s, ms};

  // Next-state: clear > lap > recall
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    age_d   = age_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      wptr_d  = '0;
      age_d   = '0;
      cnt_d   = '0;
    end else if (lap) begin
      wr_en  = 1'b1;
      wptr_d = AW'(wptr_q + AW'(1));
      age_d  = '0;
      if (cnt_q != (AW+1)'(DEPTH)) begin
        cnt_d = (AW+1)'(cnt_q + (AW+1)'(1));
      end
    end else if (recall) begin
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            state_d = VIEW;
            age_d   = '0;
          end
        end
        VIEW: begin
          if ((AW+1)'({1'b0, age_q}) < (AW+1)'(cnt_q - (AW+1)'(1))) begin
            age_d = AW'(age_q + AW'(1));
          end else begin
            state_d = IDLE;
            age_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered view data; a same-cycle capture bypasses the storage array
  always_comb begin
    full_d = (cnt_d == (AW+1)'(DEPTH));
    view_d = (state_d == VIEW);
    rd_idx = AW'(wptr_d - AW'(1) - age_d);
    disp_d = '0;
    if (state_d == VIEW) begin
      disp_d = wr_en ? live : mem_q[rd_idx];
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      age_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      view_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      age_q   <= age_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      view_q  <= view_d;
      disp_q  <= disp_d;
    end
  end

  // Storage needs no reset: lap_cnt masks stale entries
  always_ff @(posedge mclk) begin
    if (!rst && !clear && wr_en) begin
      mem_q[wptr_q] <= live;
    end
  end

  assign lap_m   = disp_q[EW-1:2*W];
  assign lap_s   = disp_q[2*W-1:W];
  assign lap_ms  = disp_q[W-1:0];
  assign lap_age = age_q;
  assign lap_cnt = cnt_q;
  assign view    = view_q;
  assign full    = full_q;

endmodule

// File: tb/tb_lap_store.sv
// Scoreboard bench for lap_store: queue-based lap model predicts each cycle's
// outputs; a negedge monitor pops and compares.
module tb_lap_store;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 2;

  logic          mclk = 1'b0;
  logic          rst, lap, recall, clear;
  logic [W-1:0]  ms, s, m;
  logic [W-1:0]  lap_ms, lap_s, lap_m;
  logic [AW-1:0] lap_age;
  logic [AW:0]   lap_cnt;
  logic          view, full;

  lap_store #(.DEPTH(DEPTH), .W(W), .AW(AW)) dut (
    .mclk(mclk), .rst(rst), .ms(ms), .s(s), .m(m),
    .lap(lap), .recall(recall), .clear(clear),
    .lap_ms(lap_ms), .lap_s(lap_s), .lap_m(lap_m), .lap_age(lap_age),
    .lap_cnt(lap_cnt), .view(view), .full(full)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int due;
    int em, es, ems, eage, ecnt, eview, efull;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 0;

  // Model state: newest lap at the back of the queue
  logic [3*W-1:0] laps[$];
  bit  mview;
  int  mage;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  // Apply one cycle of inputs, advance the model, queue the prediction.
  task automatic step(input bit r, input bit c, input bit l, input bit rc,
                      input int im, input int is, input int ims);
    exp_t e;
    rst = r; clear = c; lap = l; recall = rc;
    m = W'(im); s = W'(is); ms = W'(ims);
    if (r || c) begin
      laps.delete();
      mview = 0;
      mage  = 0;
    end else if (l) begin
      laps.push_back({W'(im), W'(is), W'(ims)});
      if (laps.size() > DEPTH) void'(laps.pop_front());
      mage = 0;
    end else if (rc) begin
      if (!mview) begin
        if (laps.size() > 0) begin mview = 1; mage = 0; end
      end else if (mage < laps.size() - 1) begin
        mage++;
      end else begin
        mview = 0; mage = 0;
      end
    end
    e.due   = cyc + 1;
    e.ecnt  = laps.size();
    e.efull = (laps.size() == DEPTH);
    e.eview = mview;
    e.eage  = mview ? mage : 0;
    if (mview) begin
      logic [3*W-1:0] ent;
      ent   = laps[laps.size() - 1 - mage];
      e.em  = ent[3*W-1:2*W];
      e.es  = ent[2*W-1:W];
      e.ems = ent[W-1:0];
    end else begin
      e.em = 0; e.es = 0; e.ems = 0;
    end
    exp_q.push_back(e);
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_cyc();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every prediction whose cycle has arrived
  always @(negedge mclk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("view",    int'(view),    e.eview);
      chk("lap_cnt", int'(lap_cnt), e.ecnt);
      chk("full",    int'(full),    e.efull);
      chk("lap_age", int'(lap_age), e.eage);
      chk("lap_m",   int'(lap_m),   e.em);
      chk("lap_s",   int'(lap_s),   e.es);
      chk("lap_ms",  int'(lap_ms),  e.ems);
    end
  end

  initial begin
    rst = 1; clear = 0; lap = 0; recall = 0; m = 0; s = 0; ms = 0;
    mview = 0; mage = 0;
    @(posedge mclk); #1;
    step(1, 0, 0, 0, 0, 0, 0);
    // Recall on empty buffer
    step(0, 0, 0, 1, 0, 0, 0);
    idle_cyc();
    // Three laps, four recalls
    step(0, 0, 1, 0, 0, 1, 10);
    step(0, 0, 1, 0, 0, 2, 20);
    step(0, 0, 1, 0, 0, 3, 30);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
    // Overwrite: five laps into four slots
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 0, i, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
    // lap + recall together while at age 1
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 9, 0);
    idle_cyc();
    // Clear from VIEW, then recall ignored
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    // Reset mid-VIEW with two laps
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 0, 1, 0, 2, 2, 2);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 7, 7, 7);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c, l, rc;
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 2) == 0);
      step(r, c, l, rc, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255));
    end
    idle_cyc();
    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge mclk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lap_store.md
Name: lap_store

Overview:
- Lap-time capture and recall buffer for the stopwatch.
- Sits downstream of the timer and upstream of the output selector. It takes the live minute, second and centisecond counts plus debounced one-cycle command pulses from the edge detector.
- Holds the last DEPTH lap times in a circular buffer. On request it presents one stored lap at a time, registered, for the output selector to route to the 7-segment path.

Parameters:
- DEPTH, 4: number of stored laps; power of two, 2..8.
- W, 8: width of each time field.
- AW, 2: pointer width, equal to log2(DEPTH).

Ports:
- mclk  input  1  system clock, same clock as the state machine and edge detector.
- rst  input  1  synchronous reset, active-high.
- ms  input  W  live centisecond count from the timer.
- s  input  W  live second count from the timer.
- m  input  W  live minute count from the timer.
- lap  input  1  one-mclk pulse: capture the current {m,s,ms}.
- recall  input  1  one-mclk pulse: enter or advance the recall view.
- clear  input  1  one-mclk pulse: discard all stored laps.
- lap_ms  output  W  centiseconds of the displayed lap; 0 when not viewing.
- lap_s  output  W  seconds of the displayed lap; 0 when not viewing.
- lap_m  output  W  minutes of the displayed lap; 0 when not viewing.
- lap_age  output  AW  age of the displayed lap; 0 = newest.
- lap_cnt  output  AW+1  number of valid stored laps, 0..DEPTH.
- view  output  1  high while a stored lap is being presented.
- full  output  1  high when lap_cnt == DEPTH.

Behaviour:
- Single clock domain: mclk. Reset is synchronous, active-high.
- Reset values: every output is 0; write pointer 0; state IDLE. Storage contents are don't-care, because lap_cnt = 0 masks them.
- Field inputs are quasi-static relative to mclk (timer ticks every 10 ms) and are sampled directly. Values pass through unmodified; no range checking.
- Priority, highest first: rst > clear > lap > recall.
  - clear in any state: lap_cnt <= 0, wptr <= 0, state <= IDLE, outputs zeroed.
  - lap and recall in the same cycle: lap is performed, recall is ignored.
- Capture on lap:
  - entry[wptr] <= {m,s,ms}; wptr <= wptr+1, wrapping modulo DEPTH.
  - lap_cnt increments and saturates at DEPTH.
  - When full, the new lap overwrites the oldest entry; lap_cnt stays at DEPTH.
  - full is registered and is asserted the cycle after the DEPTH-th capture.
- State machine, 2 states:
  - IDLE: view=0; lap_ms/lap_s/lap_m/lap_age = 0.
    - recall with lap_cnt>0 -> VIEW, age <= 0 (newest entry, index wptr-1).
    - recall with lap_cnt==0 -> stay in IDLE, no change.
  - VIEW: view=1; outputs = entry[(wptr-1-age) mod DEPTH]; lap_age = age.
    - recall with age < lap_cnt-1 -> age <= age+1 (next older entry).
    - recall with age == lap_cnt-1 -> IDLE (wrap out of the view).
    - lap while in VIEW -> capture, stay in VIEW, age <= 0. The new lap is displayed the next cycle.
- Latency: all outputs are registered. Effects of lap, recall or clear appear exactly one mclk after the pulse cycle.
- Pointer arithmetic is modulo DEPTH, so no out-of-range read is possible.
- No stored entry is visible when lap_cnt = 0.
- Pulses wider than one cycle act once per cycle. Upstream edge detection guarantees single-cycle pulses.
- Reset mid-VIEW: next cycle IDLE, all outputs 0, buffer logically empty. A recall afterwards is ignored until a lap has been captured.

Test Plan:
- Reset, then recall with the buffer empty -> view stays 0, lap_cnt=0, all outputs 0.
- Capture laps with {m,s,ms} = {0,1,10}, {0,2,20}, {0,3,30}, then apply 4 recall pulses -> outputs go to (0,3,30) age0, then (0,2,20) age1, then (0,1,10) age2, then view=0 with outputs 0. lap_cnt=3 and full=0 throughout.
- Capture 5 laps with s = 1..5 (DEPTH=4) -> lap_cnt=4, full=1. The recall sequence shows s = 5,4,3,2; s=1 has been overwritten.
- In VIEW at age1, pulse lap and recall in the same cycle with input s=9 -> next cycle age0 shows s=9, and the recall has no effect.
- In VIEW, pulse clear -> next cycle view=0, lap_cnt=0, full=0. A following recall is ignored.
- In VIEW with 2 stored laps, assert rst for one cycle -> all outputs 0 next cycle. One new capture then gives lap_cnt=1, and a recall shows only the new lap.
